// File: rtl/seq_mag_compare.sv
// -----------------------------------------------------------------------------
// seq_mag_compare
//
// Sequential wide-word magnitude comparator using HC85 cascade semantics.
// The two operands are walked one nibble per clock, least significant nibble
// first. Each nibble compare either overrides the running 3-bit result
// (when the nibbles differ) or lets it pass through unchanged (when equal).
// The most significant nibble is evaluated last, so it has the final say,
// exactly as in a chain of combinational HC85 stages.
//
// Parameters:
//   WIDTH   operand width in bits (multiple of 4, at least 4)
//
// Ports:
//   clk     system clock, rising edge active
//   rst_n   asynchronous active-low reset
//   start   operation request, only sampled while idle
//   data_a  operand A, captured when start is accepted
//   data_b  operand B, captured when start is accepted
//   cas_in  cascade input {gt,eq,lt}, normalised and captured with operands
//   busy    high while nibble steps are in progress
//   done    one-cycle pulse when q carries a fresh result
//   q       result {gt,eq,lt}; held until the next result or reset
// -----------------------------------------------------------------------------
module seq_mag_compare #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [2:0]       cas_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       q
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // HC85 treatment of the cascade inputs: any code with eq set reads as
    // equal; the two "impossible" codes 000 and 101 map onto each other.
    function automatic logic [2:0] norm_cascade(input logic [2:0] cas);
        logic [2:0] res;
        if (cas[1]) begin
            res = 3'b010;
        end else begin
            case ({cas[2], cas[0]})
                2'b10:   res = 3'b100;
                2'b01:   res = 3'b001;
                2'b00:   res = 3'b101;
                2'b11:   res = 3'b000;
                default: res = 3'b010;
            endcase
        end
        return res;
    endfunction

    // One HC85 nibble stage: a difference overrides, equality passes through.
    function automatic logic [2:0] nibble_step(
        input logic [2:0] acc,
        input logic [3:0] a_nib,
        input logic [3:0] b_nib
    );
        logic [2:0] res;
        if (a_nib > b_nib) begin
            res = 3'b100;
        end else if (a_nib < b_nib) begin
            res = 3'b001;
        end else begin
            res = acc;
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       acc_r;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       q_r;

    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [2:0]       step_acc_s;
    logic             last_step_s;

    // Select the current nibble of each latched operand and compute the step.
    always_comb begin
        a_nib_s     = 4'(a_r >> {idx_r, 2'b00});
        b_nib_s     = 4'(b_r >> {idx_r, 2'b00});
        step_acc_s  = nibble_step(acc_r, a_nib_s, b_nib_s);
        last_step_s = (idx_r == IDX_W'(NIB - 1));
    end

    // Control FSM, operand/accumulator capture and registered outputs.
    // q and done are loaded on the edge that leaves the final RUN step, so
    // they are both valid throughout the single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= 3'b000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            q_r     <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= data_a;
                        b_r     <= data_b;
                        acc_r   <= norm_cascade(cas_in);
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= step_acc_s;
                    if (last_step_s) begin
                        idx_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        q_r     <= step_acc_s;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    idx_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;

endmodule

// File: tb/tb_seq_mag_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_compare
//
// Self-checking bench for seq_mag_compare (WIDTH=16). A timestamp-based
// reference model predicts busy/done/q after every clock edge from the
// accept edge of each operation and a whole-word compare of the operands.
// Checks are made mid-cycle on the falling edge. Directed cases carry
// hand-computed expected results; random operations rely on the model.
// -----------------------------------------------------------------------------
module tb_seq_mag_compare;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [WIDTH-1:0] data_a = '0;
    logic [WIDTH-1:0] data_b = '0;
    logic [2:0]       cas_in = 3'b000;
    logic             busy;
    logic             done;
    logic [2:0]       q;

    seq_mag_compare #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data_a (data_a),
        .data_b (data_b),
        .cas_in (cas_in),
        .busy   (busy),
        .done   (done),
        .q      (q)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    logic mon_en = 1'b0;

    // Cascade code -> effective cascade value, indexed by {gt,eq,lt}.
    logic [2:0] norm_tab [0:7] = '{3'b101, 3'b001, 3'b010, 3'b010,
                                   3'b100, 3'b000, 3'b010, 3'b010};

    function automatic logic [2:0] model_result(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] cas);
        if (a > b) return 3'b100;
        else if (a < b) return 3'b001;
        else return norm_tab[cas];
    endfunction

    // Reference model: edge counter plus the edge index of the last accept.
    int         m_edge = 0;
    int         m_acc  = -1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_q    = 3'b000;
    logic [2:0] m_pend = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge <= 0;
            m_acc  <= -1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= 3'b000;
            m_pend <= 3'b000;
        end else begin
            m_edge <= m_edge + 1;
            if (start && (m_acc < 0 || m_edge + 1 >= m_acc + NIB + 2)) begin
                m_acc  <= m_edge + 1;
                m_pend <= model_result(data_a, data_b, cas_in);
                m_busy <= 1'b1;
                m_done <= 1'b0;
            end else begin
                m_busy <= (m_acc >= 0) && (m_edge + 1 <= m_acc + NIB - 1);
                m_done <= (m_acc >= 0) && (m_edge + 1 == m_acc + NIB);
                if (m_acc >= 0 && m_edge + 1 == m_acc + NIB) m_q <= m_pend;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Advance to the next falling edge and compare outputs with the model.
    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("q",    32'(q),    32'(m_q));
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] cas, input logic [2:0] expq,
                          input bit glitch);
        int n;
        int extra;
        bit seen;
        data_a = a; data_b = b; cas_in = cas; start = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (n == 2) begin
                data_a = ~a;
                data_b = 16'($urandom);
                cas_in = 3'($urandom);
                if (glitch) start = 1'b1;
            end
            if (n == 3) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", n, NIB + 1);
        chk("q_result", 32'(q), 32'(expq));
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) extra++;
        end
        chk("extra_done", extra, 0);
    endtask

    initial begin
        int last;
        int cnt;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [2:0] rc;

        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q",    32'(q),    32'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases with hand-computed results.
        run_op(16'h1234, 16'h1234, 3'b100, 3'b100, 1'b0);
        run_op(16'h1234, 16'h1234, 3'b001, 3'b001, 1'b0);
        run_op(16'h1234, 16'h1234, 3'b010, 3'b010, 1'b0);
        run_op(16'h8000, 16'h7FFF, 3'b010, 3'b100, 1'b1);
        run_op(16'h00AB, 16'h00BA, 3'b100, 3'b001, 1'b1);
        run_op(16'h5555, 16'h5555, 3'b000, 3'b101, 1'b0);
        run_op(16'h5555, 16'h5555, 3'b101, 3'b000, 1'b0);
        run_op(16'h5555, 16'h5555, 3'b111, 3'b010, 1'b0);
        run_op(16'hFFFF, 16'h0000, 3'b010, 3'b100, 1'b0);

        // Reset during the third RUN cycle aborts with no done pulse.
        data_a = 16'h0E00; data_b = 16'h0F00; cas_in = 3'b100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("busy_run3", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q",    32'(q),    32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        run_op(16'h0F00, 16'h0E00, 3'b001, 3'b100, 1'b0);

        // Random operations, checked by the model and the returned result.
        for (int k = 0; k < 30; k++) begin
            ra = 16'($urandom);
            case ($urandom_range(3, 0))
                0:       rb = ra;
                1:       rb = ra ^ (16'(4'($urandom_range(15, 1))) << (4 * $urandom_range(3, 0)));
                default: rb = 16'($urandom);
            endcase
            rc = 3'($urandom);
            run_op(ra, rb, rc, model_result(ra, rb, rc), 1'($urandom));
        end

        // Start held high: back-to-back operations every NIB+2 cycles.
        start = 1'b1;
        last = -1;
        cnt = 0;
        for (int k = 1; k <= 36; k++) begin
            data_a = 16'($urandom);
            data_b = ($urandom_range(1, 0) == 1) ? data_a : 16'($urandom);
            cas_in = 3'($urandom);
            tick();
            if (done) begin
                cnt++;
                if (last < 0) chk("hold_first", k, NIB + 1);
                else chk("hold_period", k - last, NIB + 2);
                last = k;
            end
        end
        start = 1'b0;
        repeat (8) tick();
        chk("hold_pulses", cnt, 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
